// File: rtl/filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : filter_pkg                                                     |
// | Purpose   : Shared constants and FSM state encoding for filter_ctrl.       |
// | Contents  : BYTE_W, FLUSH_LEN_DEF, state_t and the ST_* state codes.       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package filter_pkg;

  localparam int BYTE_W        = 8;
  localparam int FLUSH_LEN_DEF = 50;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FEED     = 3'd1;
  localparam logic [2:0] ST_WAIT_RES = 3'd2;
  localparam logic [2:0] ST_SEND     = 3'd3;
  localparam logic [2:0] ST_WAIT_TX  = 3'd4;
  localparam logic [2:0] ST_FLUSH    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/filter_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : filter_ctrl_if                                                 |
// | Purpose   : Bundles the UART RX, filter, UART TX and status signals of     |
// |             filter_ctrl.                                                   |
// | Modports  : master - the controller (drives flt_*, tx_start/tx_byte,       |
// |                      overflow, busy, sample_count)                         |
// |             slave  - the surroundings (RX, config, filter result, TX)      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface filter_ctrl_if
  import filter_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              rx_data_avail;
  logic [BYTE_W-1:0] rx_data_byte;
  logic              cfg_bypass;
  logic              cfg_flush;
  logic              flt_data_avail;
  logic [BYTE_W-1:0] flt_data_byte;
  logic              flt_result_avail;
  logic [BYTE_W-1:0] flt_result_byte;
  logic              tx_active;
  logic              tx_done;
  logic              tx_start;
  logic [BYTE_W-1:0] tx_byte;
  logic              overflow;
  logic              busy;
  logic [CNT_W-1:0]  sample_count;

  modport master (
    input  rx_data_avail, rx_data_byte, cfg_bypass, cfg_flush,
    input  flt_result_avail, flt_result_byte, tx_active, tx_done,
    output flt_data_avail, flt_data_byte, tx_start, tx_byte,
    output overflow, busy, sample_count
  );

  modport slave (
    output rx_data_avail, rx_data_byte, cfg_bypass, cfg_flush,
    output flt_result_avail, flt_result_byte, tx_active, tx_done,
    input  flt_data_avail, flt_data_byte, tx_start, tx_byte,
    input  overflow, busy, sample_count
  );

endinterface
`default_nettype wire

// File: rtl/filter_ctrl_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sync_fifo                                                      |
// | Purpose   : Single-clock FIFO with show-ahead head output. A push while    |
// |             full is accepted when a pop happens in the same cycle.         |
// | Ports     : clock, reset_n (async active-low)                              |
// |             push_i/din_i  - write request and data                         |
// |             pop_i         - remove head (ignored when empty)               |
// |             dout_o        - current head                                   |
// |             full_o/empty_o- status                                         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    // When full, the slot being freed by the pop is the one written.
    do_push = push_i && (!full_o || do_pop);
    dout_o  = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : filter_ctrl                                                    |
// | Purpose   : Sequences bytes from the UART receiver through the moving-     |
// |             average filter (or straight through in bypass) to the UART     |
// |             transmitter, with a flush that zeroes the filter history.      |
// | Ports     : clock, reset_n (async active-low)                              |
// |             bus (filter_ctrl_if.master) - RX strobe/byte, cfg_bypass,      |
// |             cfg_flush, filter sample/result, TX start/done handshake,      |
// |             overflow, busy, sample_count                                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FLUSH_LEN = FLUSH_LEN_DEF,
  parameter int CNT_W     = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  filter_ctrl_if.master bus
);

  localparam int              FC_W       = $clog2(FLUSH_LEN) + 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN - 1);

  state_t            state_q,     state_d;
  logic [BYTE_W-1:0] tx_byte_q,   tx_byte_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              overflow_q,  overflow_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (bus.rx_data_avail),
    .pop_i   (fifo_pop),
    .din_i   (bus.rx_data_byte),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d            = state_q;
    tx_byte_d          = tx_byte_q;
    flush_cnt_d        = flush_cnt_q;
    overflow_d         = overflow_q;
    count_d            = count_q;
    fifo_pop           = 1'b0;
    bus.flt_data_avail = 1'b0;
    bus.flt_data_byte  = '0;
    bus.tx_start       = 1'b0;
    // A flush request is latched in every state, including during a flush.
    flush_pend_d       = flush_pend_q | bus.cfg_flush;

    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          // Clearing on entry lets a cfg_flush during FLUSH queue another one.
          state_d      = ST_FLUSH;
          flush_cnt_d  = '0;
          flush_pend_d = bus.cfg_flush;
          overflow_d   = 1'b0;
          count_d      = '0;
        end else if (!fifo_empty) begin
          if (bus.cfg_bypass) begin
            fifo_pop  = 1'b1;
            tx_byte_d = fifo_head;
            state_d   = ST_SEND;
          end else begin
            state_d = ST_FEED;
          end
        end
      end
      ST_FEED: begin
        fifo_pop           = 1'b1;
        bus.flt_data_avail = 1'b1;
        bus.flt_data_byte  = fifo_head;
        state_d            = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (bus.flt_result_avail) begin
          tx_byte_d = bus.flt_result_byte;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_active) begin
          bus.tx_start = 1'b1;
          state_d      = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (bus.tx_done) begin
          count_d = count_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Filter results produced during the flush are simply not captured.
        bus.flt_data_avail = 1'b1;
        flush_cnt_d        = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Drop only when full and the same cycle does not free a slot.
    if (bus.rx_data_avail && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tx_byte_q    <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      tx_byte_q    <= tx_byte_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      count_q      <= count_d;
    end
  end

  assign bus.tx_byte      = tx_byte_q;
  assign bus.overflow     = overflow_q;
  assign bus.sample_count = count_q;
  assign bus.busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire
